// File: rtl/fir_decim_buffer.sv
// Decimating FWFT buffer behind the 9-tap FIR: drops the warm-up samples,
// keeps one sample in DECIM and streams the kept samples out over valid/ready.
module fir_decim_buffer #(
  parameter int DATA_W = 16,
  parameter int DECIM  = 4,
  parameter int WARMUP = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] sample_in,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clear_ovf,
  output logic [1:0]               o_dbg_state
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LVL_W  = AW + 1;
  localparam int WARM_W = $clog2(WARMUP + 2);
  localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
  localparam logic [PH_W-1:0]   PH_AFTER0 = (DECIM == 1) ? '0 : PH_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t              r_state, w_next_state;
  logic [WARM_W-1:0]   r_warm,  w_next_warm;
  logic [PH_W-1:0]     r_phase, w_next_phase;
  logic                w_capture;

  logic signed [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]            r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic                     r_overflow;
  logic                     w_pop, w_full, w_push, w_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_warm  <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_next_state;
      r_warm  <= w_next_warm;
      r_phase <= w_next_phase;
    end
  end

  // r_warm holds the number of samples already discarded in this run.
  always_comb begin
    w_next_state = r_state;
    w_next_warm  = r_warm;
    w_next_phase = r_phase;
    w_capture    = 1'b0;
    if (!enable) begin
      w_next_state = S_IDLE;
      w_next_warm  = '0;
      w_next_phase = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (WARMUP == 0) begin
            w_capture    = 1'b1;
            w_next_state = S_RUN;
            w_next_phase = PH_AFTER0;
          end else begin
            w_next_state = S_WARM;
            w_next_warm  = WARM_W'(1);
          end
        end
        S_WARM: begin
          if (r_warm == WARM_LAST) begin
            w_capture    = 1'b1;
            w_next_state = S_RUN;
            w_next_warm  = '0;
            w_next_phase = PH_AFTER0;
          end else begin
            w_next_warm = r_warm + WARM_W'(1);
          end
        end
        S_RUN: begin
          w_capture    = (r_phase == '0);
          w_next_phase = (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_warm  = '0;
          w_next_phase = '0;
        end
      endcase
    end
  end

  // Valid/ready: a sample transfers on every edge where m_valid and m_ready
  // are both high; m_valid never depends on m_ready.
  assign m_valid = (r_level != '0);
  assign w_pop   = m_valid & m_ready;
  assign w_full  = (r_level == FULL_LVL);
  assign w_push  = w_capture & (~w_full | w_pop);
  assign w_drop  = w_capture & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
      // A drop on the same edge as clear_ovf keeps the flag set.
      if (w_drop)         r_overflow <= 1'b1;
      else if (clear_ovf) r_overflow <= 1'b0;
    end
  end

  assign m_data      = m_valid ? r_mem[r_rd_ptr] : '0;
  assign level       = r_level;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Bench for fir_decim_buffer: directed scenarios, a sample-index model of the
// kept/dropped samples, and literal expectations on the drained sequences.
module tb_fir_decim_buffer;

  localparam int DATA_W = 16;
  localparam int DECIM  = 4;
  localparam int WARMUP = 8;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic [DATA_W-1:0] sample_in;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [4:0]        level;
  logic              overflow;
  logic              clear_ovf;
  logic [1:0]        dbg_state;

  int checks   = 0;
  int failures = 0;
  int drv_k    = 0;
  int lvl_max  = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              exp_ovf;
  int                mk;

  fir_decim_buffer #(
    .DATA_W(DATA_W), .DECIM(DECIM), .WARMUP(WARMUP), .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sample_in  (sample_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .level      (level),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // model: cycle k since enable rise is captured when k = WARMUP + n*DECIM
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_ovf = 1'b0;
      mk      = 0;
    end else begin
      bit pop, wr, drop;
      int sz;
      sz   = exp_q.size();
      pop  = (sz > 0) && m_ready;
      wr   = enable && (mk >= WARMUP) && (((mk - WARMUP) % DECIM) == 0);
      drop = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (wr) begin
        if (sz < DEPTH || pop) exp_q.push_back(sample_in);
        else drop = 1'b1;
      end
      if (drop) exp_ovf = 1'b1;
      else if (clear_ovf) exp_ovf = 1'b0;
      mk = enable ? mk + 1 : 0;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    check("m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
    check("m_data", 32'(m_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'd0);
    check("level", 32'(level), 32'(exp_q.size()));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    if (int'(level) > lvl_max) lvl_max = int'(level);
    if (rst_n && m_valid && m_ready) got_q.push_back(m_data);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (enable) drv_k++;
    else drv_k = 0;
    sample_in = DATA_W'(drv_k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; clear_ovf = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    got_q.delete();
    lvl_max = 0;
  endtask

  task automatic check_arith(input string name, input int start, input int n);
    check({name, "_count"}, 32'(got_q.size()), 32'(n));
    for (int i = 0; i < n && i < got_q.size(); i++)
      check(name, 32'(got_q[i]), 32'(start + DECIM * i));
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; m_ready = 1'b0; clear_ovf = 1'b0; sample_in = '0;
    #1;
    check("reset_m_valid", 32'(m_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);

    // streaming with consumer always ready
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    repeat (40) step();
    check_arith("stream_seq", 8, 8);
    check("stream_lvl_max", 32'(lvl_max), 32'd1);
    check("stream_ovf", 32'(overflow), 32'd0);

    // fill, overflow, clear on a drop edge keeps the flag, drain
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 80; i++) begin
      clear_ovf = (i == 72);
      step();
      if (i == 68) check("full_level", 32'(level), 32'd16);
      if (i == 71) check("full_no_ovf", 32'(overflow), 32'd0);
      if (i == 72) check("ovf_set_wins", 32'(overflow), 32'd1);
    end
    clear_ovf = 1'b0;
    check("ovf_level", 32'(level), 32'd16);
    enable = 1'b0; m_ready = 1'b1;
    repeat (20) step();
    check_arith("drain_seq", 8, 16);
    check("ovf_held", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    step();
    clear_ovf = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // full FIFO with a pop on the capture edge
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i <= 72; i++) begin
      m_ready = (i == 72);
      step();
    end
    m_ready = 1'b0;
    check("pushpop_level", 32'(level), 32'd16);
    check("pushpop_ovf", 32'(overflow), 32'd0);
    enable = 1'b0; m_ready = 1'b1;
    repeat (20) step();
    check_arith("pushpop_seq", 8, 17);

    // disable with three held samples, then re-enable
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      m_ready = (i <= 20);
      step();
    end
    m_ready = 1'b0;
    check("hold_level", 32'(level), 32'd3);
    enable = 1'b0;
    repeat (4) step();
    check("hold_level_idle", 32'(level), 32'd3);
    check("hold_state_idle", 32'(dbg_state), 32'd0);
    enable = 1'b1; m_ready = 1'b1;
    repeat (40) step();
    begin
      int exp_seq [8] = '{8, 12, 16, 20, 24, 28, 8, 12};
      for (int i = 0; i < 8; i++)
        check("reenable_seq", (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_seq[i]));
    end

    // asynchronous reset with data held and overflow set
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    repeat (80) step();
    enable = 1'b0; m_ready = 1'b1;
    repeat (11) step();
    m_ready = 1'b0;
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_m_valid", 32'(m_valid), 32'd0);
    check("async_m_data", 32'(m_data), 32'd0);
    check("async_level", 32'(level), 32'd0);
    check("async_ovf", 32'(overflow), 32'd0);

    // negative and extreme samples pass bit-exact
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8)  sample_in = 16'h8000;
      if (i == 12) sample_in = 16'hFFFF;
      if (i == 16) sample_in = 16'h7FFF;
      step();
    end
    check("neg_level", 32'(level), 32'd3);
    enable = 1'b0; m_ready = 1'b1;
    repeat (6) step();
    check("neg_count", 32'(got_q.size()), 32'd3);
    check("neg_0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 32'h8000);
    check("neg_1", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hFFFF_FFFF, 32'hFFFF);
    check("neg_2", (got_q.size() > 2) ? 32'(got_q[2]) : 32'hFFFF_FFFF, 32'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
